serial_io_bus_bridge: RTL
=========================

// Module: serial_io_bus_bridge
// PURPOSE
//  Avalon-MM slave that turns HPS bridge read/write requests in the FF21_xxxx serial-IO window
//  into timed 16550-style bus cycles: setup, strobe, hold. It drives Address/IOSelect_H/ByteSelect_L
//  into the downstream serial IO port decoder (RS232/GPS/Bluetooth/TouchScreen/Wifi enables) and
//  RW/data to the UART cores, stretching AvWaitRequest until the slow bus cycle completes.
// PARAMETERS
//  SETUP_CYCLES   2  cycles Address/RW/data stable before IOSelect_H rises (0 allowed: phase skipped)
//  STROBE_CYCLES  4  cycles IOSelect_H held high (must be >= 1)
//  HOLD_CYCLES    1  cycles Address/RW/data held after IOSelect_H falls (0 allowed: phase skipped)
// PORTS
//  Clock            in   1   system clock
//  Reset            in   1   synchronous, active-high reset
//  AvChipSelect     in   1   Avalon chip select for the FF21_xxxx window
//  AvRead           in   1   Avalon read request
//  AvWrite          in   1   Avalon write request
//  AvAddress        in   16  byte address A15:A0 within the window
//  AvByteEnable     in   2   [1]=D15-D8 lane, [0]=D7-D0 lane
//  AvWriteData      in   16  write data
//  AvReadData       out  16  read data, valid in the cycle AvWaitRequest is low after a read
//  AvWaitRequest    out  1   stall to Avalon master
//  Address          out  16  registered bus address to decoder and UARTs
//  IOSelect_H       out  1   bus strobe, high during STROBE phase only
//  ByteSelect_L     out  1   low when upper lane (AvByteEnable[1]) selected
//  RW               out  1   1=read, 0=write
//  DataOut          out  16  registered write data to UARTs
//  DataOutEnable_H  out  1   tri-state drive enable, high SETUP..HOLD on writes only
//  DataIn           in   16  read data from UARTs
// BEHAVIOUR
//  - Reset values: AvReadData=0, Address=0, IOSelect_H=0, ByteSelect_L=1, RW=1, DataOut=0,
//    DataOutEnable_H=0, state=IDLE. Reset mid-transfer abandons the cycle; no completion is issued.
//  - States IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE; zero-length SETUP/HOLD phases skipped.
//  - IDLE: on AvChipSelect & (AvRead|AvWrite), latch AvAddress, ByteSelect_L=~AvByteEnable[1],
//    RW, AvWriteData; load phase counter; go to SETUP. AvRead & AvWrite both high: write wins.
//  - Request inputs ignored outside IDLE; a master withdrawing its request mid-cycle does not abort
//    the bus cycle, which completes with latched values.
//  - STROBE: IOSelect_H=1. On final STROBE cycle, reads capture DataIn into AvReadData.
//  - DONE: one cycle; AvWaitRequest low, transfer accepted; always returns to IDLE (one idle cycle
//    minimum between bus cycles).
//  - AvWaitRequest (combinational) = AvChipSelect & (AvRead|AvWrite) & (state != DONE);
//    low when no request is present.
//  - Latency, request sampled to acceptance: SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 cycles
//    (defaults: 8; acceptance in cycle 8 counting request cycle as 0).
//  - Phase counter: down-counter, width $clog2(max param + 1), loaded with (phase length - 1);
//    phase ends at 0; never wraps.
//  - AvReadData holds its last captured value until the next read capture.
// STRUCTURE
//  - serial_io_pkg: state enum (IDLE, SETUP, STROBE, HOLD, DONE); default timing constants;
//    port base constants RS232=16'h0200, GPS=16'h0210, BT=16'h0220, TOUCH=16'h0230, WIFI=16'h0240.
//  - Sub-module io_phase_counter: loadable down-counter with load, value and zero flag.
// TESTING
//  1. Write AvAddress=0x0210, AvByteEnable=2'b10, AvWriteData=0xAB00 -> cycles 1-7: Address=0x0210,
//     ByteSelect_L=0, RW=0, DataOut=0xAB00, DataOutEnable_H=1; IOSelect_H=1 in cycles 3-6 only;
//     AvWaitRequest low in cycle 8 only.
//  2. Read 0x0220 with DataIn=0x5A00 during STROBE -> RW=1, DataOutEnable_H=0 throughout;
//     AvReadData=0x5A00 in cycle 8.
//  3. Reset pulsed in cycle 4 (STROBE) -> next cycle IOSelect_H=0, all outputs at reset values;
//     no DONE occurs until a new request.
//  4. Request held high across two back-to-back writes -> exactly one IDLE cycle between DONE and
//     the next SETUP; IOSelect_H low >= HOLD_CYCLES+SETUP_CYCLES+2 cycles between strobes.
//  5. AvRead=AvWrite=1 at 0x0240 -> write cycle (RW=0) performed; AvChipSelect=0 with AvWrite=1
//     -> no bus activity, AvWaitRequest=0.
//  6. SETUP_CYCLES=0, HOLD_CYCLES=0 -> IOSelect_H high cycles 1-4; AvWaitRequest low in cycle 5.

Source files
------------

// File: rtl/serial_io_pkg.sv
// Shared types and constants for the serial-IO bus bridge: bus-cycle states,
// default phase timing and the decoder base addresses of the serial ports.
package serial_io_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } bus_state_t;

    localparam int DEF_SETUP_CYCLES  = 2;
    localparam int DEF_STROBE_CYCLES = 4;
    localparam int DEF_HOLD_CYCLES   = 1;

    localparam logic [15:0] RS232_BASE = 16'h0200;
    localparam logic [15:0] GPS_BASE   = 16'h0210;
    localparam logic [15:0] BT_BASE    = 16'h0220;
    localparam logic [15:0] TOUCH_BASE = 16'h0230;
    localparam logic [15:0] WIFI_BASE  = 16'h0240;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/io_phase_counter.sv
// Loadable down-counter timing one bus phase; it parks at zero instead of
// wrapping so a phase that is not reloaded simply stays finished.
module io_phase_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/serial_io_bus_bridge.sv
// Avalon-MM slave that stretches each request into a timed setup/strobe/hold
// bus cycle towards the serial-IO port decoder and the 16550-style UARTs.
//
// state  | meaning
// IDLE   | waiting for a request; latches address/lane/direction/data on accept
// SETUP  | address, RW and write data settle before the strobe
// STROBE | IOSelect_H high; read data captured on the last strobe cycle
// HOLD   | address, RW and write data held after the strobe falls
// DONE   | AvWaitRequest released for one cycle; always followed by IDLE
module serial_io_bus_bridge
    import serial_io_pkg::*;
#(
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        AvChipSelect,
    input  logic        AvRead,
    input  logic        AvWrite,
    input  logic [15:0] AvAddress,
    input  logic [1:0]  AvByteEnable,
    input  logic [15:0] AvWriteData,
    output logic [15:0] AvReadData,
    output logic        AvWaitRequest,
    output logic [15:0] Address,
    output logic        IOSelect_H,
    output logic        ByteSelect_L,
    output logic        RW,
    output logic [15:0] DataOut,
    output logic        DataOutEnable_H,
    input  logic [15:0] DataIn
);

    localparam int CW = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES) + 1);

    localparam logic [CW-1:0] SETUP_LOAD  = (SETUP_CYCLES > 0)  ? CW'(SETUP_CYCLES - 1)  : '0;
    localparam logic [CW-1:0] STROBE_LOAD = (STROBE_CYCLES > 0) ? CW'(STROBE_CYCLES - 1) : '0;
    localparam logic [CW-1:0] HOLD_LOAD   = (HOLD_CYCLES > 0)   ? CW'(HOLD_CYCLES - 1)   : '0;

    bus_state_t    state;
    bus_state_t    state_nxt;
    logic          request;
    logic          cnt_load;
    logic [CW-1:0] cnt_load_value;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;
    logic          strobe_last;

    assign request = AvChipSelect & (AvRead | AvWrite);

    io_phase_counter #(
        .WIDTH(CW)
    ) u_phase_counter (
        .clk_sys    (Clock),
        .reset      (Reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .value      (cnt_value),
        .zero       (cnt_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Zero-length setup/hold phases are bypassed when the phase is entered,
    // so the counter is only ever loaded for phases that really exist.
    always_comb begin
        state_nxt      = state;
        cnt_load       = 1'b0;
        cnt_load_value = '0;
        case (state)
            IDLE: begin
                if (request) begin
                    cnt_load = 1'b1;
                    if (SETUP_CYCLES > 0) begin
                        state_nxt      = SETUP;
                        cnt_load_value = SETUP_LOAD;
                    end else begin
                        state_nxt      = STROBE;
                        cnt_load_value = STROBE_LOAD;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nxt      = STROBE;
                    cnt_load       = 1'b1;
                    cnt_load_value = STROBE_LOAD;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    if (HOLD_CYCLES > 0) begin
                        state_nxt      = HOLD;
                        cnt_load       = 1'b1;
                        cnt_load_value = HOLD_LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        IOSelect_H      = 1'b0;
        DataOutEnable_H = 1'b0;
        AvWaitRequest   = 1'b0;
        if (state == STROBE) begin
            IOSelect_H = 1'b1;
        end
        if ((state == SETUP) || (state == STROBE) || (state == HOLD)) begin
            DataOutEnable_H = ~RW;
        end
        if (request && (state != DONE)) begin
            AvWaitRequest = 1'b1;
        end
    end

    assign strobe_last = (state == STROBE) && (cnt_value == '0);

    // Bus-side signals are captured once at acceptance and stay frozen for
    // the whole cycle, whatever the master does with its request meanwhile.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Address      <= '0;
            ByteSelect_L <= 1'b1;
            RW           <= 1'b1;
            DataOut      <= '0;
            AvReadData   <= '0;
        end else begin
            if ((state == IDLE) && request) begin
                Address      <= AvAddress;
                ByteSelect_L <= ~AvByteEnable[1];
                RW           <= ~AvWrite;
                DataOut      <= AvWriteData;
            end
            if (strobe_last && RW) begin
                AvReadData <= DataIn;
            end
        end
    end

endmodule
